car_parking_ctrl_param: RTL

- Parametrised next-generation single-gate parking controller.
- Gates entry with a two-field password check, including a retry limit, entry timeout and lockout.
- Tracks occupancy against a configurable capacity, counts cumulative entries, and drives green/red gate lights plus two 7-segment digits showing free spaces.
- Sits between the gate sensors/keypad and the gate actuator and display.

---
 rtl/car_parm_pkg.sv | 41 ++++
 rtl/car_parking_ctrl_param_seven_seg_dec.sv | 25 ++
 rtl/car_parking_ctrl_param.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/car_parm_pkg.sv
// Shared types and helpers for the parking controller: FSM encoding, active-low
// 7-segment patterns {g..a}, and a binary-to-tens/ones split for values up to 99.
package car_parm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_PWD  = 3'd1,
        ST_GRANT     = 3'd2,
        ST_DENY      = 3'd3,
        ST_FULL_WAIT = 3'd4,
        ST_LOCKED    = 3'd5
    } park_state_e;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Returns {tens, ones}; repeated subtraction is bounded at nine steps for 0..99.
    function automatic logic [7:0] bcd_split(input logic [6:0] value);
        logic [3:0] tens;
        logic [6:0] rem;
        tens = 4'd0;
        rem  = value;
        for (int i = 0; i < 9; i++) begin
            if (rem >= 7'd10) begin
                rem  = rem - 7'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

endpackage

// File: rtl/car_parking_ctrl_param_seven_seg_dec.sv
// Single-digit 7-segment decoder, active-low {g..a}; non-decimal codes blank.
module seven_seg_dec
    import car_parm_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/car_parking_ctrl_param.sv
// Single-gate parking controller: password-gated entry, occupancy tracking, lights, display.
// Lockout after repeated wrong passwords is built only when PARK_LOCKOUT_EN is defined.
module car_parking_ctrl_param
    import car_parm_pkg::*;
#(
    parameter int CAPACITY      = 8,
    parameter int PWD_W         = 2,
    parameter int PASS_1        = 1,
    parameter int PASS_2        = 2,
    parameter int MAX_TRIES     = 3,
    parameter int ENTRY_TIMEOUT = 16,
    parameter int LOCK_CYCLES   = 32,
    localparam int CNT_W        = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sense_entry,
    input  logic             sense_exit,
    input  logic             pwd_valid,
    input  logic [PWD_W-1:0] password_1,
    input  logic [PWD_W-1:0] password_2,
    output logic             green_light,
    output logic             red_light,
    output logic             locked,
    output logic             full,
    output logic [6:0]       hex_1,
    output logic [6:0]       hex_2,
    output logic [CNT_W-1:0] space_available,
    output logic [CNT_W-1:0] space_utilized,
    output logic [CNT_W-1:0] count_cars
);

    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int TMR_W = $clog2(ENTRY_TIMEOUT + 1);

    park_state_e      state, state_nxt;
    logic [TMR_W-1:0] timer;
    logic [TRY_W-1:0] tries;
    logic             exit_q, exit_edge, ent_done;
    logic             pwd_try, pwd_ok, lock_done;
    logic [7:0]       digits;

    assign exit_edge       = sense_exit & ~exit_q;
    assign pwd_try         = (state == ST_WAIT_PWD) && sense_entry && pwd_valid;
    assign pwd_ok          = (password_1 == PWD_W'(PASS_1)) && (password_2 == PWD_W'(PASS_2));
    assign full            = (space_utilized == CNT_W'(CAPACITY));
    assign space_available = CNT_W'(CAPACITY) - space_utilized;

`ifdef PARK_LOCKOUT_EN
    localparam int LCK_W = $clog2(LOCK_CYCLES + 1);
    logic [LCK_W-1:0] lock_timer;

    assign lock_done = (state == ST_LOCKED) && (lock_timer == LCK_W'(LOCK_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            lock_timer <= '0;
            locked     <= 1'b0;
        end else begin
            lock_timer <= (state == ST_LOCKED && !lock_done) ? lock_timer + 1'b1 : '0;
            locked     <= (state_nxt == ST_LOCKED);
        end
    end
`else
    assign lock_done = 1'b0;
    assign locked    = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        ent_done  = 1'b0;
        case (state)
            ST_IDLE:
                if (sense_entry) state_nxt = full ? ST_FULL_WAIT : ST_WAIT_PWD;
            ST_WAIT_PWD:
                if (!sense_entry)                              state_nxt = ST_IDLE;
                else if (pwd_valid)                            state_nxt = pwd_ok ? ST_GRANT : ST_DENY;
                else if (timer == TMR_W'(ENTRY_TIMEOUT - 1))   state_nxt = ST_IDLE;
            ST_GRANT:
                if (!sense_entry) begin
                    state_nxt = ST_IDLE;
                    ent_done  = 1'b1;
                end
`ifdef PARK_LOCKOUT_EN
            ST_DENY:
                state_nxt = (tries == TRY_W'(MAX_TRIES)) ? ST_LOCKED : ST_WAIT_PWD;
            ST_LOCKED:
                if (lock_done) state_nxt = ST_IDLE;
`else
            ST_DENY:
                state_nxt = ST_WAIT_PWD;
`endif
            ST_FULL_WAIT:
                if (!sense_entry) state_nxt = ST_IDLE;
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= ST_IDLE;
            timer          <= '0;
            tries          <= '0;
            exit_q         <= 1'b0;
            space_utilized <= '0;
            count_cars     <= '0;
            green_light    <= 1'b0;
            red_light      <= 1'b0;
        end else begin
            state  <= state_nxt;
            exit_q <= sense_exit;
            // Timer runs only while staying in WAIT_PWD, so every (re)entry starts at zero.
            timer  <= (state == ST_WAIT_PWD && state_nxt == ST_WAIT_PWD) ? timer + 1'b1 : '0;

            if (pwd_try)
                tries <= pwd_ok ? '0 : ((tries == TRY_W'(MAX_TRIES)) ? tries : tries + 1'b1);
            else if (lock_done)
                tries <= '0;

            green_light <= (state_nxt == ST_GRANT);
            red_light   <= (state_nxt == ST_DENY) || (state_nxt == ST_FULL_WAIT) ||
                           (state_nxt == ST_LOCKED);

            if (ent_done)
                count_cars <= count_cars + 1'b1;
            // A simultaneous entry and exit cancel out on occupancy.
            if (ent_done && !exit_edge)
                space_utilized <= space_utilized + 1'b1;
            else if (!ent_done && exit_edge && space_utilized != '0)
                space_utilized <= space_utilized - 1'b1;
        end
    end

    assign digits = bcd_split(7'(space_available));

    seven_seg_dec u_dec_tens (.digit(digits[7:4]), .seg(hex_1));
    seven_seg_dec u_dec_ones (.digit(digits[3:0]), .seg(hex_2));

endmodule
